// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Instruction fetch stage. The PC register drives the combinational lookup
//   (tlb_addr), and the returned word is registered as the instruction. When
//   the word carries the MVI opcode, the following word is also fetched as its
//   immediate before the instruction is offered. A complete instruction is
//   offered to the core in HOLD and is consumed by a valid/ready handshake. A
//   redirect (pc_load) is honoured only on the accepting edge.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            asynchronous, active-high reset
//   i_run            start/restart request (used only in IDLE and DONE)
//   o_tlb_addr       lookup address, always equal to the PC register
//   i_tlb_out        word returned by the lookup for o_tlb_addr, same cycle
//   o_instr          registered instruction word
//   o_imm            registered immediate (meaningful when o_has_imm=1)
//   o_has_imm        o_instr is MVI and o_imm holds its operand
//   o_instr_valid    instruction offered to the core
//   i_instr_ready    core can take the offered instruction
//   i_pc_load        redirect request, used on the accepting edge only
//   i_pc_load_value  redirect target
//   o_pc             current fetch pointer
//   o_done           program end reached, fetching stopped
//   o_dbg_state      current FSM state, for observation only
//
// Handshake: an instruction transfers on a rising edge where o_instr_valid
// and i_instr_ready are both high. o_instr_valid, once raised, stays high and
// o_instr/o_imm/o_has_imm/o_pc stay unchanged until that transfer happens.
// ============================================================================
module fetch_unit #(
  parameter int         ADDR_W     = 6,
  parameter int         DATA_W     = 16,
  parameter int         PROG_LEN   = 38,
  parameter logic [3:0] MVI_OPCODE = 4'b0001
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  output logic [ADDR_W-1:0] o_tlb_addr,
  input  logic [DATA_W-1:0] i_tlb_out,
  output logic [DATA_W-1:0] o_instr,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_has_imm,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  input  logic              i_pc_load,
  input  logic [ADDR_W-1:0] i_pc_load_value,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_done,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_FETCH_IMM = 3'd2,
    S_HOLD      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // Truncation to ADDR_W is intentional: PROG_LEN == 2**ADDR_W makes the end
  // marker 0, which the PC reaches by wrapping.
  localparam logic [ADDR_W-1:0] END_PC = ADDR_W'(PROG_LEN);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_instr;
  logic [DATA_W-1:0]   r_imm;
  logic                r_has_imm;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [DATA_W-1:0]   w_instr_nxt;
  logic [DATA_W-1:0]   w_imm_nxt;
  logic                w_has_imm_nxt;
  logic                w_is_mvi;

  assign w_is_mvi = (i_tlb_out[9:6] == MVI_OPCODE);

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_instr   <= '0;
      r_imm     <= '0;
      r_has_imm <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_imm     <= w_imm_nxt;
      r_has_imm <= w_has_imm_nxt;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_imm_nxt     = r_imm;
    w_has_imm_nxt = r_has_imm;

    case (r_state)
      S_IDLE: begin
        if (i_run) w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        w_instr_nxt   = i_tlb_out;
        w_imm_nxt     = '0;
        w_has_imm_nxt = 1'b0;
        w_pc_nxt      = r_pc + ADDR_W'(1);
        w_state_nxt   = w_is_mvi ? S_FETCH_IMM : S_HOLD;
      end

      S_FETCH_IMM: begin
        // The immediate is taken even if the lookup misses past the end.
        w_imm_nxt     = i_tlb_out;
        w_has_imm_nxt = 1'b1;
        w_pc_nxt      = r_pc + ADDR_W'(1);
        w_state_nxt   = S_HOLD;
      end

      S_HOLD: begin
        if (i_instr_ready) begin
          // A redirect takes priority over the end-of-program check.
          if (i_pc_load) begin
            w_pc_nxt    = i_pc_load_value;
            w_state_nxt = S_FETCH;
          end else if (r_pc == END_PC) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end

      S_DONE: begin
        if (i_run) begin
          w_pc_nxt    = '0;
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_tlb_addr    = r_pc;
  assign o_pc          = r_pc;
  assign o_instr       = r_instr;
  assign o_imm         = r_imm;
  assign o_has_imm     = r_has_imm;
  assign o_instr_valid = (r_state == S_HOLD);
  assign o_done        = (r_state == S_DONE);
  assign o_dbg_state   = r_state;

endmodule
